// File: rtl/game_sequencer_if.sv
// Game-flow bundle between the sequencer, the button/collision sources and the object datapath.
// master = sequencer side; slave = datapath/debouncer side.
interface game_sequencer_if #(
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               start;
    logic               shark_hit;
    logic [1:0]         bottle_hit;
    logic               move_en;
    logic               obj_reset;
    logic [1:0]         bottle_vis;
    logic [1:0]         lives;
    logic [SCORE_W-1:0] score;
    logic               q_IDLE;
    logic               q_PLAY;
    logic               q_HIT;
    logic               q_WIN;
    logic               q_LOSE;
    logic [1:0]         bg_sel;

    modport master (
        input  frame_tick, start, shark_hit, bottle_hit,
        output move_en, obj_reset, bottle_vis, lives, score,
        output q_IDLE, q_PLAY, q_HIT, q_WIN, q_LOSE, bg_sel
    );

    modport slave (
        output frame_tick, start, shark_hit, bottle_hit,
        input  move_en, obj_reset, bottle_vis, lives, score,
        input  q_IDLE, q_PLAY, q_HIT, q_WIN, q_LOSE, bg_sel
    );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow FSM for the ocean-cleanup game: lives, score, bottle respawn, background select.
// Outputs registered (1-cycle latency); events qualified by frame_tick; no backpressure.
module game_sequencer #(
    parameter int LIVES      = 3,
    parameter int WIN_SCORE  = 8,
    parameter int SCORE_W    = 4,
    parameter int HIT_FRAMES = 60,
    parameter int RESPAWN_FR = 120
) (
    input  logic                clk,
    input  logic                rst,
    game_sequencer_if.master    bus
);
    localparam int HIT_W = $clog2(HIT_FRAMES + 1);
    localparam int RSP_W = $clog2(RESPAWN_FR + 1);

    localparam logic [1:0]         LIVES_V  = 2'(LIVES);
    localparam logic [SCORE_W-1:0] WIN_V    = SCORE_W'(WIN_SCORE);
    localparam logic [HIT_W-1:0]   HIT_LAST = HIT_W'(HIT_FRAMES - 1);
    localparam logic [RSP_W-1:0]   RSP_LAST = RSP_W'(RESPAWN_FR - 1);

    // One-hot so each q_* output is a flop directly.
    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_PLAY = 5'b00010,
        S_HIT  = 5'b00100,
        S_WIN  = 5'b01000,
        S_LOSE = 5'b10000
    } state_t;

    state_t                  state;
    logic [HIT_W-1:0]        hit_cnt;
    logic [1:0][RSP_W-1:0]   rsp;

    logic [1:0]              collect;
    logic [1:0]              n_col;
    logic [SCORE_W:0]        sum;
    logic [SCORE_W-1:0]      score_sat;
    logic                    win;
    logic [1:0]              vis_nxt;
    logic [1:0][RSP_W-1:0]   rsp_nxt;

    // A shark hit on the same frame masks any bottle pickup.
    assign collect   = bus.bottle_hit & bus.bottle_vis & {2{~bus.shark_hit}};
    assign n_col     = {1'b0, collect[0]} + {1'b0, collect[1]};
    assign sum       = {1'b0, bus.score} + {{(SCORE_W-1){1'b0}}, n_col};
    assign score_sat = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    assign win       = (score_sat >= WIN_V);

    always_comb begin
        vis_nxt = bus.bottle_vis;
        rsp_nxt = rsp;
        for (int i = 0; i < 2; i++) begin
            if (collect[i]) begin
                vis_nxt[i] = 1'b0;
                rsp_nxt[i] = '0;
            end else if (!bus.bottle_vis[i]) begin
                if (rsp[i] == RSP_LAST)
                    vis_nxt[i] = 1'b1;
                else
                    rsp_nxt[i] = rsp[i] + RSP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            hit_cnt        <= '0;
            rsp            <= '0;
            bus.obj_reset  <= 1'b0;
            bus.bottle_vis <= 2'b11;
            bus.lives      <= LIVES_V;
            bus.score      <= '0;
        end else begin
            bus.obj_reset <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state          <= S_PLAY;
                        bus.obj_reset  <= 1'b1;
                        bus.lives      <= LIVES_V;
                        bus.score      <= '0;
                        bus.bottle_vis <= 2'b11;
                        rsp            <= '0;
                    end
                end
                S_PLAY: begin
                    if (bus.frame_tick) begin
                        bus.bottle_vis <= vis_nxt;
                        rsp            <= rsp_nxt;
                        if (bus.shark_hit) begin
                            bus.lives <= (bus.lives == 2'd0) ? 2'd0 : bus.lives - 2'd1;
                            hit_cnt   <= '0;
                            state     <= (bus.lives <= 2'd1) ? S_LOSE : S_HIT;
                        end else begin
                            bus.score <= score_sat;
                            if (win)
                                state <= S_WIN;
                        end
                    end
                end
                S_HIT: begin
                    // Freeze period: respawn counters and score untouched here.
                    if (bus.frame_tick) begin
                        if (hit_cnt == HIT_LAST) begin
                            state         <= S_PLAY;
                            bus.obj_reset <= 1'b1;
                        end else begin
                            hit_cnt <= hit_cnt + HIT_W'(1);
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    if (bus.start)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.q_IDLE  = state[0];
    assign bus.q_PLAY  = state[1];
    assign bus.q_HIT   = state[2];
    assign bus.q_WIN   = state[3];
    assign bus.q_LOSE  = state[4];
    assign bus.move_en = state[1];
    // 0 black, 1 ocean (play/hit), 2 white, 3 red
    assign bus.bg_sel  = {state[3] | state[4], state[1] | state[2] | state[4]};
endmodule
